// File: rtl/pc_next_unit.sv
// Program-counter register and next-PC selector: sequential, jump, branch and jr targets,
// with stall-time redirect capture and a sticky halt on misaligned jr targets.
module pc_next_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             jump_en_i,
  input  logic [31:0]      jump_ext_i,
  input  logic             branch_en_i,
  input  logic [31:0]      branch_off_i,
  input  logic             jr_en_i,
  input  logic [31:0]      jr_addr_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      pc_plus4_o,
  output logic             redirect_o,
  output logic             pend_o,
  output logic             misalign_o,
  output logic [CNT_W-1:0] fetch_cnt_o
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pend_tgt_q, pend_tgt_d;
  logic             redirect_q, redirect_d;
  logic             pend_q, pend_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] pc_plus4_s;
  logic [31:0] tgt_j_s;
  logic [31:0] tgt_b_s;
  logic [31:0] tgt_sel_s;
  logic        any_en_s;
  logic        jr_bad_s;
  logic        unused_bits_s;

  assign pc_plus4_s    = pc_q + 32'd4;
  assign tgt_j_s       = {pc_plus4_s[31:28], jump_ext_i[25:0], 2'b00};
  assign tgt_b_s       = pc_plus4_s + {branch_off_i[29:0], 2'b00};
  assign any_en_s      = jr_en_i | jump_en_i | branch_en_i;
  assign jr_bad_s      = jr_en_i & (jr_addr_i[1:0] != 2'b00);
  assign unused_bits_s = ^{jump_ext_i[31:26], branch_off_i[31:30]};

  // Target priority: jr over jump over branch.
  always_comb begin
    tgt_sel_s = tgt_b_s;
    if (jr_en_i) begin
      tgt_sel_s = jr_addr_i;
    end else if (jump_en_i) begin
      tgt_sel_s = tgt_j_s;
    end else begin
      tgt_sel_s = tgt_b_s;
    end
  end

  // Next-state logic for RUN/HOLD/HALT.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_tgt_d = pend_tgt_q;
    redirect_d = 1'b0;
    pend_d     = pend_q;
    misalign_d = misalign_q;
    cnt_d      = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (jr_bad_s) begin
          misalign_d = 1'b1;
          state_d    = ST_HALT;
        end else if (stall_i) begin
          if (any_en_s) begin
            pend_tgt_d = tgt_sel_s;
            pend_d     = 1'b1;
            state_d    = ST_HOLD;
          end else begin
            pend_d = 1'b0;
          end
        end else begin
          if (any_en_s) begin
            pc_d       = tgt_sel_s;
            redirect_d = 1'b1;
          end else begin
            pc_d = pc_plus4_s;
          end
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        // The first captured redirect wins; enables seen here are dropped.
        if (stall_i) begin
          pend_d = 1'b1;
        end else begin
          pc_d       = pend_tgt_q;
          pend_d     = 1'b0;
          redirect_d = 1'b1;
          cnt_d      = cnt_q + CNT_W'(1);
          state_d    = ST_RUN;
        end
      end
      ST_HALT: begin
        misalign_d = 1'b1;
      end
      default: begin
        pend_d  = 1'b0;
        state_d = ST_RUN;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      pend_tgt_q <= 32'h0000_0000;
      redirect_q <= 1'b0;
      pend_q     <= 1'b0;
      misalign_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_tgt_q <= pend_tgt_d;
      redirect_q <= redirect_d;
      pend_q     <= pend_d;
      misalign_q <= misalign_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pc_o        = pc_q;
  assign pc_plus4_o  = pc_plus4_s;
  assign redirect_o  = redirect_q;
  assign pend_o      = pend_q;
  assign misalign_o  = misalign_q;
  assign fetch_cnt_o = cnt_q;

endmodule
